// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one variable-latency memory port between fetch and data requesters
module mem_port_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MAX_D_BURST = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_valid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_ack,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              busy,
    output logic              err_tmo
);

    localparam int SW = $clog2(MAX_D_BURST + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {S_IDLE, S_G_FETCH, S_G_DATA} state_t;

    state_t            r_state;
    logic              r_m_we;
    logic [ADDR_W-1:0] r_m_addr;
    logic [DATA_W-1:0] r_m_wdata;
    logic              r_if_valid;
    logic              r_d_valid;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_d_rdata;
    logic              r_err_tmo;
    logic [SW-1:0]     r_starv_cnt;
    logic [TW-1:0]     r_tmo_cnt;

    logic w_starved;
    logic w_grant_d;
    logic w_grant_f;
    logic w_tmo_last;

    // Data wins ties unless fetch has already been passed over MAX_D_BURST times.
    assign w_starved  = (r_starv_cnt == SW'(MAX_D_BURST));
    assign w_grant_d  = d_req && !(if_req && w_starved);
    assign w_grant_f  = if_req && !w_grant_d;
    assign w_tmo_last = (r_tmo_cnt == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_m_we      <= 1'b0;
            r_m_addr    <= '0;
            r_m_wdata   <= '0;
            r_if_valid  <= 1'b0;
            r_d_valid   <= 1'b0;
            r_if_rdata  <= '0;
            r_d_rdata   <= '0;
            r_err_tmo   <= 1'b0;
            r_starv_cnt <= '0;
            r_tmo_cnt   <= '0;
        end else begin
            r_if_valid <= 1'b0;
            r_d_valid  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_grant_d) begin
                        r_state   <= S_G_DATA;
                        r_m_we    <= d_we;
                        r_m_addr  <= d_addr;
                        r_m_wdata <= d_wdata;
                        r_tmo_cnt <= '0;
                        if (if_req)
                            r_starv_cnt <= r_starv_cnt + SW'(1);
                    end else if (w_grant_f) begin
                        r_state     <= S_G_FETCH;
                        r_m_we      <= 1'b0;
                        r_m_addr    <= if_addr;
                        r_m_wdata   <= '0;
                        r_tmo_cnt   <= '0;
                        r_starv_cnt <= '0;
                    end
                end
                S_G_FETCH, S_G_DATA: begin
                    if (m_ack) begin
                        r_state <= S_IDLE;
                        if (r_state == S_G_FETCH) begin
                            r_if_valid <= 1'b1;
                            r_if_rdata <= m_rdata;
                        end else begin
                            r_d_valid <= 1'b1;
                            if (!r_m_we)
                                r_d_rdata <= m_rdata;
                        end
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + TW'(1);
                        // Abort: the owner still gets its valid pulse, with zero read data.
                        if (w_tmo_last) begin
                            r_state   <= S_IDLE;
                            r_err_tmo <= 1'b1;
                            if (r_state == S_G_FETCH) begin
                                r_if_valid <= 1'b1;
                                r_if_rdata <= '0;
                            end else begin
                                r_d_valid <= 1'b1;
                                if (!r_m_we)
                                    r_d_rdata <= '0;
                            end
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy     = (r_state != S_IDLE);
    assign m_req    = busy;
    assign m_we     = r_m_we;
    assign m_addr   = r_m_addr;
    assign m_wdata  = r_m_wdata;
    assign if_valid = r_if_valid;
    assign if_rdata = r_if_rdata;
    assign d_valid  = r_d_valid;
    assign d_rdata  = r_d_rdata;
    assign err_tmo  = r_err_tmo;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_valid;
    logic [31:0] if_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        d_valid;
    logic [31:0] d_rdata;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_ack = 1'b0;
    logic [31:0] m_rdata = '0;
    logic        busy;
    logic        err_tmo;

    int n_checks = 0;
    int n_errors = 0;

    mem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MAX_D_BURST(4), .TIMEOUT_CYC(8)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_valid(d_valid), .d_rdata(d_rdata),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_ack(m_ack), .m_rdata(m_rdata), .busy(busy), .err_tmo(err_tmo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("valid_exclusive", 32'(if_valid && d_valid), 32'd0);
            chk("valid_vs_mreq", 32'((if_valid || d_valid) && m_req), 32'd0);
        end
    end

    initial begin
        cyc();
        chk("rst_mreq", 32'(m_req), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ifv", 32'(if_valid), 0);
        chk("rst_dv", 32'(d_valid), 0);
        chk("rst_drdata", d_rdata, 0);
        chk("rst_ifrdata", if_rdata, 0);
        chk("rst_err", 32'(err_tmo), 0);
        rst = 1'b0;

        // 1: single fetch, ack on second G cycle
        if_req = 1'b1; if_addr = 32'h10;
        cyc();
        chk("t1_mreq_c1", 32'(m_req), 1);
        chk("t1_maddr", m_addr, 32'h10);
        chk("t1_mwe", 32'(m_we), 0);
        cyc();
        chk("t1_mreq_c2", 32'(m_req), 1);
        chk("t1_ifv_early", 32'(if_valid), 0);
        m_ack = 1'b1; m_rdata = 32'h8C010004;
        cyc();
        m_ack = 1'b0; if_req = 1'b0;
        chk("t1_mreq_off", 32'(m_req), 0);
        chk("t1_ifv", 32'(if_valid), 1);
        chk("t1_ifrdata", if_rdata, 32'h8C010004);
        cyc();
        chk("t1_ifv_once", 32'(if_valid), 0);
        chk("t1_busy", 32'(busy), 0);

        // 2: simultaneous requests, data first then fetch
        if_req = 1'b1; if_addr = 32'h20; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
        cyc();
        chk("t2_maddr_d", m_addr, 32'h200);
        m_ack = 1'b1; m_rdata = 32'h0000D00D;
        cyc();
        m_ack = 1'b0; d_req = 1'b0;
        chk("t2_dv", 32'(d_valid), 1);
        chk("t2_drdata", d_rdata, 32'h0000D00D);
        chk("t2_idle", 32'(m_req), 0);
        cyc();
        chk("t2_maddr_f", m_addr, 32'h20);
        chk("t2_mreq_f", 32'(m_req), 1);
        m_ack = 1'b1; m_rdata = 32'h0000F00F;
        cyc();
        m_ack = 1'b0; if_req = 1'b0;
        chk("t2_ifv", 32'(if_valid), 1);
        chk("t2_ifrdata", if_rdata, 32'h0000F00F);
        cyc();

        // 3: both held, starvation guard gives D,D,D,D,F,D,D,D,D,F
        if_req = 1'b1; if_addr = 32'h40; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500;
        for (int i = 0; i < 10; i++) begin
            logic is_f;
            is_f = (i == 4) || (i == 9);
            cyc();
            chk($sformatf("t3_mreq_%0d", i), 32'(m_req), 1);
            chk($sformatf("t3_grant_%0d", i), m_addr, is_f ? 32'h40 : 32'h500);
            m_ack = 1'b1; m_rdata = 32'h1000 + 32'(i);
            cyc();
            m_ack = 1'b0;
            if (i == 9) begin
                if_req = 1'b0; d_req = 1'b0;
            end
            if (is_f) begin
                chk($sformatf("t3_ifv_%0d", i), 32'(if_valid), 1);
                chk($sformatf("t3_ifrd_%0d", i), if_rdata, 32'h1000 + 32'(i));
            end else begin
                chk($sformatf("t3_dv_%0d", i), 32'(d_valid), 1);
                chk($sformatf("t3_drd_%0d", i), d_rdata, 32'h1000 + 32'(i));
            end
        end
        cyc();
        chk("t3_idle", 32'(busy), 0);

        // 4: data read never acked, timeout after 8 cycles
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
        for (int i = 0; i < 8; i++) begin
            cyc();
            chk($sformatf("t4_mreq_%0d", i), 32'(m_req), 1);
            chk($sformatf("t4_err_%0d", i), 32'(err_tmo), 0);
        end
        cyc();
        d_req = 1'b0; m_ack = 1'b1; m_rdata = 32'hBAD0BAD0;
        chk("t4_mreq_drop", 32'(m_req), 0);
        chk("t4_dv", 32'(d_valid), 1);
        chk("t4_drdata", d_rdata, 0);
        chk("t4_err", 32'(err_tmo), 1);
        cyc();
        m_ack = 1'b0;
        chk("t4_late_ack_dv", 32'(d_valid), 0);
        chk("t4_late_ack_busy", 32'(busy), 0);
        chk("t4_late_ack_drd", d_rdata, 0);
        chk("t4_err_sticky", 32'(err_tmo), 1);

        // 6: read to seed d_rdata, then a write that must not change it
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h304;
        cyc();
        m_ack = 1'b1; m_rdata = 32'hA5A55A5A;
        cyc();
        m_ack = 1'b0; d_req = 1'b0;
        chk("t6_seed", d_rdata, 32'hA5A55A5A);
        cyc();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'h1234;
        cyc();
        chk("t6_mwe", 32'(m_we), 1);
        chk("t6_maddr", m_addr, 32'h100);
        chk("t6_mwdata", m_wdata, 32'h1234);
        m_ack = 1'b1; m_rdata = 32'hDEADBEEF;
        cyc();
        m_ack = 1'b0; d_req = 1'b0; d_we = 1'b0;
        chk("t6_dv", 32'(d_valid), 1);
        chk("t6_drd_kept", d_rdata, 32'hA5A55A5A);
        cyc();

        // 5: reset during G_DATA, then a stray ack
        d_req = 1'b1; d_addr = 32'h308;
        cyc();
        chk("t5_granted", 32'(m_req), 1);
        rst = 1'b1;
        #1;
        chk("t5_mreq_async", 32'(m_req), 0);
        chk("t5_busy_async", 32'(busy), 0);
        chk("t5_err_clr", 32'(err_tmo), 0);
        chk("t5_drd_clr", d_rdata, 0);
        d_req = 1'b0;
        cyc();
        rst = 1'b0; m_ack = 1'b1; m_rdata = 32'h55555555;
        cyc();
        m_ack = 1'b0;
        chk("t5_no_dv", 32'(d_valid), 0);
        chk("t5_busy", 32'(busy), 0);
        chk("t5_mreq", 32'(m_req), 0);
        chk("t5_drd", d_rdata, 0);
        cyc();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
